io_tx_fifo: RTL and testbench
=============================

Name: io_tx_fifo

Overview:
- Sits directly downstream of the CPU core's memory bus, alongside the RAM.
- Captures CPU byte writes to the memory-mapped I/O window: 0x30000 carries output bytes and 0x30004 signals program stop.
- Buffers captured bytes in a FIFO and drains them to the UART transmitter over a valid/ready handshake.
- Produces the io_buffer_full back-pressure signal that the core's memory controller consumes, plus a cycle counter and a program-done flag.

Parameters:
FIFO_WIDTH, 4, log2 of FIFO depth (DEPTH = 1 << FIFO_WIDTH = 16)
FULL_MARGIN, 2, free slots reserved for CPU writes already in flight when io_buffer_full rises; must satisfy 1 <= FULL_MARGIN < DEPTH

Ports:
clk_in  input  1  system clock
rst_in  input  1  reset, asynchronous, active-low
rdy_in  input  1  CPU ready; low freezes CPU-side capture and the cycle counter
mem_a  input  32  CPU address bus; only [17:0] decoded
mem_dout  input  8  CPU write data
mem_wr  input  1  CPU write strobe (1 = write)
io_buffer_full  output  1  back-pressure to the CPU's memory controller
tx_data  output  8  byte presented to the UART transmitter
tx_valid  output  1  tx_data valid
tx_ready  input  1  UART transmitter accepts the byte
program_done  output  1  sticky; terminator byte has been transmitted
overflow  output  1  sticky; a byte was dropped because the FIFO was full
fifo_count  output  FIFO_WIDTH+1  current occupancy, 0..DEPTH
cycle_count  output  32  cycles elapsed while rdy_in high, before done

Behaviour:
- Clock and reset: one clock, clk_in. rst_in is asynchronous and active-low; rst_in = 0 immediately clears all state.
- Reset values: tx_valid=0, tx_data=0, program_done=0, overflow=0, fifo_count=0, cycle_count=0, io_buffer_full=0, state=RUN, FIFO pointers=0.
- Reset mid-operation discards FIFO contents and any half-accepted handshake.
- I/O hit: rdy_in && mem_wr && mem_a[17:16]==2'b11.
  - mem_a[2]==0 (0x30000) with mem_dout!=0: data push.
  - mem_a[2]==0 with mem_dout==0: ignored.
  - mem_a[2]==1 (0x30004): terminator push of byte 0x00, and state moves to DRAIN.
- Non-I/O writes and all reads are ignored.
- State machine:
  - RUN: accepts data pushes and the terminator.
  - DRAIN: all further pushes ignored (no overflow flagged); FIFO keeps draining.
  - DONE: entered on the cycle the terminator is popped. program_done=1 from the next edge. Pushes ignored. Holds until reset.
- Terminator tagging: the terminator is tagged by a 9th storage bit, so a popped data byte is never mistaken for it.
- Push/pop rules:
  - Push writes at the tail on the clock edge.
  - Pop occurs on any edge where tx_valid && tx_ready. Pop is independent of rdy_in.
  - tx_valid = (fifo_count != 0); tx_data = head entry, registered storage, no bypass. A byte pushed into an empty FIFO appears on tx_valid the following cycle.
  - tx_data must stay stable while tx_valid && !tx_ready.
  - Simultaneous push and pop: both happen; fifo_count unchanged. This holds when full too, so the push is accepted.
  - Push when fifo_count==DEPTH with no pop: byte dropped, overflow set (sticky), count unchanged. A terminator push is never dropped: if the FIFO is full, the terminator is held pending and enqueued on the first cycle a slot frees.
- Pointers: FIFO_WIDTH bits, wrap modulo DEPTH. fifo_count derived from the difference between pointers extended by one bit.
- io_buffer_full = (fifo_count >= DEPTH - FULL_MARGIN). It is combinational from registered count, no extra latency.
- cycle_count:
  - Increments by 1 on every edge with rdy_in=1 and state!=DONE.
  - Wraps modulo 2^32.
  - Frozen after program_done.

Test Plan:
1. Reset then write 0x41,0x42 to 0x30000 with tx_ready=1 -> tx_valid high one cycle after each push; tx_data 0x41 then 0x42; fifo_count returns to 0.
2. Write 0x00 to 0x30000, and write 0x55 to 0x00010 -> nothing enqueued; fifo_count stays 0; tx_valid stays 0.
3. tx_ready=0, push 14 bytes -> io_buffer_full rises when fifo_count=14. Push 2 more -> count=16. One more -> dropped, overflow=1, count=16. Then a simultaneous push+pop at count 16 -> count stays 16, byte accepted.
4. Push 0x61, then write 0x30004, then push 0x62 -> FIFO holds 0x61 and the tagged 0x00; 0x62 ignored. After both pop, program_done=1 one cycle after the terminator pop; cycle_count frozen.
5. Hold rdy_in=0 for 10 cycles while mem_wr=1 at 0x30000 -> no pushes; cycle_count unchanged; queued bytes still drain with tx_ready=1.
6. Assert rst_in=0 asynchronously mid-drain with count=5 -> all outputs take reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/io_tx_fifo_if.sv
// Byte stream from the I/O transmit FIFO to the UART transmitter.
// The master presents tx_data/tx_valid; the slave answers with tx_ready.
interface io_tx_fifo_if;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/io_tx_fifo.sv
// Captures CPU byte writes to the 0x30000 I/O window into a FIFO
// and drains them to the UART; 0x30004 queues a tagged stop marker.
module io_tx_fifo #(
    parameter int FIFO_WIDTH  = 4,
    parameter int FULL_MARGIN = 2
) (
    input  logic                  clk_in,
    input  logic                  rst_in,
    input  logic                  rdy_in,
    input  logic [31:0]           mem_a,
    input  logic [7:0]            mem_dout,
    input  logic                  mem_wr,
    output logic                  io_buffer_full,
    io_tx_fifo_if.master          tx,
    output logic                  program_done,
    output logic                  overflow,
    output logic [FIFO_WIDTH:0]   fifo_count,
    output logic [31:0]           cycle_count
);
    localparam int DEPTH = 1 << FIFO_WIDTH;
    localparam logic [FIFO_WIDTH:0] DEPTH_C  = (FIFO_WIDTH+1)'(DEPTH);
    localparam logic [FIFO_WIDTH:0] THRESH_C =
        (FIFO_WIDTH+1)'(DEPTH - FULL_MARGIN);

    localparam logic [1:0] S_RUN   = 2'd0;
    localparam logic [1:0] S_DRAIN = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    // Bit 8 tags the stop marker so a data byte can never alias it.
    logic [8:0]          mem_q [DEPTH];
    logic [FIFO_WIDTH:0] wr_ptr_q, wr_ptr_d;
    logic [FIFO_WIDTH:0] rd_ptr_q, rd_ptr_d;
    logic [1:0]          state_q, state_d;
    logic                term_pend_q, term_pend_d;
    logic                overflow_q, overflow_d;
    logic [31:0]         cycle_q, cycle_d;

    logic [FIFO_WIDTH:0] cnt;
    logic [8:0]          head;
    logic [8:0]          wdata;
    logic                valid, pop, push;
    logic                hit, data_req, term_req, term_want;
    logic                free, push_data, push_term, drop;
    logic                unused_addr;

    assign unused_addr = ^{mem_a[31:18], mem_a[15:3], mem_a[1:0]};

    always_comb begin
        cnt       = wr_ptr_q - rd_ptr_q;
        head      = mem_q[rd_ptr_q[FIFO_WIDTH-1:0]];
        valid     = (cnt != '0);
        pop       = valid && tx.tx_ready;
        hit       = rdy_in && mem_wr && (mem_a[17:16] == 2'b11);
        data_req  = hit && !mem_a[2] && (mem_dout != 8'h00)
                    && (state_q == S_RUN);
        term_req  = hit && mem_a[2] && (state_q == S_RUN);
        term_want = term_req || term_pend_q;
        // A pop on the same edge frees the slot the push lands in.
        free      = (cnt != DEPTH_C) || pop;
        push_term = term_want && free;
        push_data = data_req && free;
        drop      = data_req && !free;
        push      = push_term || push_data;
        wdata     = push_term ? 9'h100 : {1'b0, mem_dout};

        wr_ptr_d    = push ? wr_ptr_q + 1'b1 : wr_ptr_q;
        rd_ptr_d    = pop  ? rd_ptr_q + 1'b1 : rd_ptr_q;
        term_pend_d = term_want && !free;
        overflow_d  = overflow_q || drop;

        state_d = state_q;
        if (term_req) begin
            state_d = S_DRAIN;
        end
        if (pop && head[8]) begin
            state_d = S_DONE;
        end

        cycle_d = cycle_q;
        if (rdy_in && (state_q != S_DONE)) begin
            cycle_d = cycle_q + 32'd1;
        end
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            state_q     <= S_RUN;
            term_pend_q <= 1'b0;
            overflow_q  <= 1'b0;
            cycle_q     <= '0;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            state_q     <= state_d;
            term_pend_q <= term_pend_d;
            overflow_q  <= overflow_d;
            cycle_q     <= cycle_d;
        end
    end

    always_ff @(posedge clk_in) begin
        if (push) begin
            mem_q[wr_ptr_q[FIFO_WIDTH-1:0]] <= wdata;
        end
    end

    assign tx.tx_valid     = valid;
    assign tx.tx_data      = valid ? head[7:0] : 8'h00;
    assign fifo_count      = cnt;
    assign io_buffer_full  = (cnt >= THRESH_C);
    assign program_done    = (state_q == S_DONE);
    assign overflow        = overflow_q;
    assign cycle_count     = cycle_q;
endmodule

// File: tb/tb_io_tx_fifo.sv
// Directed bench for io_tx_fifo: vector table plus hand-built
// sequences for stop marker, pending marker, stall and async reset.
module tb_io_tx_fifo;
    logic        clk;
    logic        rst_n;
    logic        rdy;
    logic [31:0] addr;
    logic [7:0]  dout;
    logic        wr;
    logic        full;
    logic        done;
    logic        ovf;
    logic [4:0]  cnt;
    logic [31:0] cc;

    int total = 0;
    int bad   = 0;

    io_tx_fifo_if tx_if ();

    io_tx_fifo dut (
        .clk_in         (clk),
        .rst_in         (rst_n),
        .rdy_in         (rdy),
        .mem_a          (addr),
        .mem_dout       (dout),
        .mem_wr         (wr),
        .io_buffer_full (full),
        .tx             (tx_if),
        .program_done   (done),
        .overflow       (ovf),
        .fifo_count     (cnt),
        .cycle_count    (cc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        rdy;
        logic        wr;
        logic [31:0] a;
        logic [7:0]  d;
        logic        trdy;
        logic        ev;
        logic [7:0]  edata;
        logic [4:0]  ecnt;
        logic        efull;
        logic        eovf;
    } vec_t;

    vec_t tv[$];

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s got=%0h want=%0h", nm, act, exp);
        end
    endtask

    task automatic add(input logic r, input logic w, input logic [31:0] a,
                       input logic [7:0] d, input logic t, input logic ev,
                       input logic [7:0] ed, input logic [4:0] ec,
                       input logic ef, input logic eo);
        vec_t v;
        v.rdy = r; v.wr = w; v.a = a; v.d = d; v.trdy = t;
        v.ev = ev; v.edata = ed; v.ecnt = ec; v.efull = ef; v.eovf = eo;
        tv.push_back(v);
    endtask

    task automatic drive(input logic r, input logic w, input logic [31:0] a,
                         input logic [7:0] d, input logic t);
        rdy = r; wr = w; addr = a; dout = d; tx_if.tx_ready = t;
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut();
        rdy = 1'b1; wr = 1'b0; addr = '0; dout = '0; tx_if.tx_ready = 1'b0;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    task automatic chk_state(input string nm, input logic ev,
                             input logic [7:0] ed, input logic [4:0] ec,
                             input logic ef, input logic eo, input logic edn);
        chk({nm, ".valid"}, tx_if.tx_valid, ev);
        chk({nm, ".data"},  tx_if.tx_data, ed);
        chk({nm, ".count"}, cnt, ec);
        chk({nm, ".full"},  full, ef);
        chk({nm, ".ovf"},   ovf, eo);
        chk({nm, ".done"},  done, edn);
    endtask

    initial begin
        clk = 1'b0;
        rst_n = 1'b0;
        rdy = 1'b1; wr = 1'b0; addr = '0; dout = '0; tx_if.tx_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk_state("rst0", 0, 8'h00, 5'd0, 0, 0, 0);
        chk("rst0.cc", cc, 32'd0);
        rst_n = 1'b1;

        add(1, 1, 32'h30000, 8'h41, 1, 1, 8'h41, 5'd1, 0, 0);
        add(1, 1, 32'h30000, 8'h42, 1, 1, 8'h42, 5'd1, 0, 0);
        add(1, 0, 32'h30000, 8'h00, 1, 0, 8'h00, 5'd0, 0, 0);
        add(1, 1, 32'h30000, 8'h00, 1, 0, 8'h00, 5'd0, 0, 0);
        add(1, 1, 32'h00010, 8'h55, 1, 0, 8'h00, 5'd0, 0, 0);
        add(1, 1, 32'h20000, 8'h33, 1, 0, 8'h00, 5'd0, 0, 0);
        add(1, 0, 32'h30000, 8'h77, 1, 0, 8'h00, 5'd0, 0, 0);
        for (int k = 1; k <= 16; k++) begin
            add(1, 1, 32'h30000, 8'(k), 0, 1, 8'h01, 5'(k), k >= 14, 0);
        end
        add(1, 1, 32'h30000, 8'h11, 0, 1, 8'h01, 5'd16, 1, 1);
        add(1, 1, 32'h30000, 8'h12, 1, 1, 8'h02, 5'd16, 1, 1);
        for (int j = 1; j <= 16; j++) begin
            logic [7:0] hd;
            hd = (j <= 14) ? 8'(j + 2) : ((j == 15) ? 8'h12 : 8'h00);
            add(1, 0, 32'h0, 8'h00, 1, j != 16, hd, 5'(16 - j),
                (16 - j) >= 14, 1);
        end

        for (int i = 0; i < tv.size(); i++) begin
            string nm;
            nm = $sformatf("vec%0d", i);
            drive(tv[i].rdy, tv[i].wr, tv[i].a, tv[i].d, tv[i].trdy);
            chk({nm, ".valid"}, tx_if.tx_valid, tv[i].ev);
            chk({nm, ".data"},  tx_if.tx_data, tv[i].edata);
            chk({nm, ".count"}, cnt, tv[i].ecnt);
            chk({nm, ".full"},  full, tv[i].efull);
            chk({nm, ".ovf"},   ovf, tv[i].eovf);
        end
        chk("vec.cc", cc, 32'(tv.size()));

        // stop marker path
        reset_dut();
        drive(1, 1, 32'h30000, 8'h61, 0);
        chk_state("t4a", 1, 8'h61, 5'd1, 0, 0, 0);
        drive(1, 1, 32'h30004, 8'hAA, 0);
        chk_state("t4b", 1, 8'h61, 5'd2, 0, 0, 0);
        drive(1, 1, 32'h30000, 8'h62, 0);
        chk_state("t4c", 1, 8'h61, 5'd2, 0, 0, 0);
        drive(1, 1, 32'h30004, 8'h63, 0);
        chk_state("t4d", 1, 8'h61, 5'd2, 0, 0, 0);
        drive(1, 0, 32'h0, 8'h00, 1);
        chk_state("t4e", 1, 8'h00, 5'd1, 0, 0, 0);
        drive(1, 0, 32'h0, 8'h00, 1);
        chk_state("t4f", 0, 8'h00, 5'd0, 0, 0, 1);
        chk("t4f.cc", cc, 32'd6);
        repeat (3) drive(1, 0, 32'h0, 8'h00, 1);
        drive(1, 1, 32'h30000, 8'h64, 1);
        chk_state("t4g", 0, 8'h00, 5'd0, 0, 0, 1);
        chk("t4g.cc", cc, 32'd6);

        // stop marker while full is held, not dropped
        reset_dut();
        for (int k = 1; k <= 16; k++) drive(1, 1, 32'h30000, 8'(k), 0);
        chk_state("tpa", 1, 8'h01, 5'd16, 1, 0, 0);
        drive(1, 1, 32'h30004, 8'h00, 0);
        chk_state("tpb", 1, 8'h01, 5'd16, 1, 0, 0);
        drive(1, 0, 32'h0, 8'h00, 1);
        chk_state("tpc", 1, 8'h02, 5'd16, 1, 0, 0);
        repeat (15) drive(1, 0, 32'h0, 8'h00, 1);
        chk_state("tpd", 1, 8'h00, 5'd1, 0, 0, 0);
        drive(1, 0, 32'h0, 8'h00, 1);
        chk_state("tpe", 0, 8'h00, 5'd0, 0, 0, 1);

        // rdy_in low freezes capture and counter but not the drain
        reset_dut();
        drive(1, 1, 32'h30000, 8'h21, 0);
        drive(1, 1, 32'h30000, 8'h22, 0);
        drive(1, 1, 32'h30000, 8'h23, 0);
        chk("t5a.cc", cc, 32'd3);
        repeat (10) drive(0, 1, 32'h30000, 8'h99, 0);
        chk_state("t5b", 1, 8'h21, 5'd3, 0, 0, 0);
        chk("t5b.cc", cc, 32'd3);
        drive(0, 0, 32'h0, 8'h00, 1);
        chk_state("t5c", 1, 8'h22, 5'd2, 0, 0, 0);
        drive(0, 0, 32'h0, 8'h00, 1);
        drive(0, 0, 32'h0, 8'h00, 1);
        chk_state("t5d", 0, 8'h00, 5'd0, 0, 0, 0);
        chk("t5d.cc", cc, 32'd3);

        // asynchronous reset mid-drain
        reset_dut();
        for (int k = 1; k <= 6; k++) drive(1, 1, 32'h30000, 8'(k + 8'h30), 0);
        drive(1, 0, 32'h0, 8'h00, 1);
        tx_if.tx_ready = 1'b0;
        chk_state("t6a", 1, 8'h32, 5'd5, 0, 0, 0);
        #3;
        rst_n = 1'b0;
        #1;
        chk_state("t6b", 0, 8'h00, 5'd0, 0, 0, 0);
        chk("t6b.cc", cc, 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
